// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_t;

    // Data-bit configuration as seen on cfg_data_bits.
    typedef enum logic [1:0] {
        DB5 = 2'b00,
        DB6 = 2'b01,
        DB7 = 2'b10,
        DB8 = 2'b11
    } data_bits_t;

    // Number of data bits on the line for a given configuration.
    function automatic logic [3:0] bit_count(input data_bits_t db);
        return 4'd5 + {2'b00, db};
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Per-bit tick counter with 3-point majority vote around the bit centre.
// Held at cnt=0 whenever i_en is low, so the FSM restarts it simply by
// dropping enable for a cycle (IDLE / BRK_WAIT).
module uart_bit_sampler #(
    parameter int OVERSAMPLE_RATE = 16
) (
    input  logic uart_clk,
    input  logic uart_rst_n,
    input  logic i_tick,
    input  logic i_en,
    input  logic i_line,
    output logic o_bit_val,
    output logic o_bit_done,
    output logic o_bit_end
);

    localparam int CW = $clog2(OVERSAMPLE_RATE);
    localparam int M  = OVERSAMPLE_RATE / 2;

    logic [CW-1:0] r_cnt;
    logic          r_s0;
    logic          r_s1;

    // Count ticks within the bit and capture the two early samples.
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            r_cnt <= '0;
            r_s0  <= 1'b0;
            r_s1  <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(M - 1)) r_s0 <= i_line;
            if (r_cnt == CW'(M))     r_s1 <= i_line;
        end
    end

    // Third sample is the live line at cnt=M+1, so the vote is ready that cycle.
    assign o_bit_val  = (r_s0 & r_s1) | (r_s0 & i_line) | (r_s1 & i_line);
    assign o_bit_done = i_en & i_tick & (r_cnt == CW'(M + 1));
    assign o_bit_end  = i_en & i_tick & (r_cnt == CW'(OVERSAMPLE_RATE - 1));

endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampled UART frame receiver: start/data/parity/stop decoding with
// parity, frame-error and break status, delivered over valid/ready.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int OVERSAMPLE_RATE = 16
) (
    input  logic                  uart_clk,
    input  logic                  uart_rst_n,
    input  logic                  sample_tick,
    input  logic                  rx_serial_sync,
    input  logic [1:0]            cfg_data_bits,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_parity_odd,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_error,
    output logic                  frame_error,
    output logic                  break_detect,
    output logic                  overrun,
    output logic                  rx_active
);

    rx_state_t   r_state;
    rx_state_t   w_next;
    logic [2:0]  r_bit_idx;
    logic [3:0]  r_nbits;
    logic        r_par_en;
    logic        r_par_odd;
    logic [7:0]  r_shift;
    logic        r_par_bit;
    logic        r_par_err;

    logic        w_en;
    logic        w_bit_val;
    logic        w_bit_done;
    logic        w_bit_end;
    logic        w_last;
    logic        w_start;
    logic        w_emit;
    logic        w_brk;

    assign w_en    = (r_state == START) || (r_state == DATA) ||
                     (r_state == PARITY) || (r_state == STOP);
    assign w_last  = ({1'b0, r_bit_idx} == (r_nbits - 4'd1));
    assign w_start = (r_state == IDLE) && sample_tick && !rx_serial_sync;
    assign w_emit  = (r_state == STOP) && w_bit_done;
    // Break: everything seen on the line was 0, including the stop bit.
    assign w_brk   = !w_bit_val && (r_shift == 8'd0) && (!r_par_en || !r_par_bit);

    uart_bit_sampler #(
        .OVERSAMPLE_RATE(OVERSAMPLE_RATE)
    ) u_sampler (
        .uart_clk   (uart_clk),
        .uart_rst_n (uart_rst_n),
        .i_tick     (sample_tick),
        .i_en       (w_en),
        .i_line     (rx_serial_sync),
        .o_bit_val  (w_bit_val),
        .o_bit_done (w_bit_done),
        .o_bit_end  (w_bit_end)
    );

    // FSM state register.
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) r_state <= IDLE;
        else             r_state <= w_next;
    end

    // Next-state decode; sampler strobes already include sample_tick.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_start) w_next = START;
            START:    if (w_bit_done && w_bit_val) w_next = IDLE;
                      else if (w_bit_end)          w_next = DATA;
            DATA:     if (w_bit_end && w_last) w_next = r_par_en ? PARITY : STOP;
            PARITY:   if (w_bit_end) w_next = STOP;
            STOP:     if (w_bit_done) w_next = w_bit_val ? IDLE : BRK_WAIT;
            BRK_WAIT: if (sample_tick && rx_serial_sync) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Frame datapath: latch config at start, shift data LSB first, check parity.
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            r_bit_idx <= '0;
            r_nbits   <= 4'd8;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
        end else if (w_start) begin
            r_bit_idx <= '0;
            r_nbits   <= bit_count(data_bits_t'(cfg_data_bits));
            r_par_en  <= cfg_parity_en;
            r_par_odd <= cfg_parity_odd;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
        end else if (r_state == DATA) begin
            if (w_bit_done)           r_shift[r_bit_idx] <= w_bit_val;
            if (w_bit_end && !w_last) r_bit_idx <= r_bit_idx + 3'd1;
        end else if ((r_state == PARITY) && w_bit_done) begin
            r_par_bit <= w_bit_val;
            r_par_err <= w_bit_val ^ (^r_shift) ^ r_par_odd;
        end
    end

    // Output holding register with valid/ready and overrun drop.
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            break_detect <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (w_emit && rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else if (w_emit) begin
                rx_data      <= DATA_WIDTH'(r_shift);
                rx_valid     <= 1'b1;
                parity_error <= r_par_en && r_par_err;
                frame_error  <= !w_bit_val;
                break_detect <= w_brk;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign rx_active = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: frame-level stimulus with a character scoreboard.
module tb_uart_rx_deserializer;

    localparam int OSR = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    logic       uart_clk = 1'b0;
    logic       uart_rst_n;
    logic       sample_tick;
    logic       rx_serial_sync;
    logic [1:0] cfg_data_bits;
    logic       cfg_parity_en;
    logic       cfg_parity_odd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_error;
    logic       frame_error;
    logic       break_detect;
    logic       overrun;
    logic       rx_active;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_valid_cyc = 0;
    int   n_ovr = 0;
    int   v0;
    int   o0;

    uart_rx_deserializer #(
        .DATA_WIDTH(8),
        .OVERSAMPLE_RATE(OSR)
    ) dut (
        .uart_clk       (uart_clk),
        .uart_rst_n     (uart_rst_n),
        .sample_tick    (sample_tick),
        .rx_serial_sync (rx_serial_sync),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .parity_error   (parity_error),
        .frame_error    (frame_error),
        .break_detect   (break_detect),
        .overrun        (overrun),
        .rx_active      (rx_active)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One sample_tick pulse; inputs change 2 ns after a rising edge.
    task automatic tick();
        @(posedge uart_clk); #2 sample_tick = 1'b1;
        @(posedge uart_clk); #2 sample_tick = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx_serial_sync = b;
        repeat (OSR) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic pbit, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(stop);
    endtask

    task automatic expect_char(input logic [7:0] d, input logic pe, input logic fe,
                               input logic brk);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe; e.brk = brk;
        sb.push_back(e);
    endtask

    // Monitor on the falling edge: inputs are stable, transfer happens at next rise.
    always @(negedge uart_clk) begin
        exp_t e;
        if (rx_valid) n_valid_cyc++;
        if (overrun)  n_ovr++;
        if (rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_xfer", {24'd0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("rx_data",      {24'd0, rx_data}, {24'd0, e.d});
                chk("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
                chk("frame_error",  {31'd0, frame_error},  {31'd0, e.fe});
                chk("break_detect", {31'd0, break_detect}, {31'd0, e.brk});
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        uart_rst_n     = 1'b0;
        sample_tick    = 1'b0;
        rx_serial_sync = 1'b1;
        rx_ready       = 1'b1;
        cfg_data_bits  = 2'b11;
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        repeat (4) @(posedge uart_clk);
        #2;
        chk("reset_outputs",
            {18'd0, rx_data, rx_valid, parity_error, frame_error, break_detect, overrun, rx_active},
            32'd0);
        uart_rst_n = 1'b1;
        send_bit(1'b1);

        // 1: 8N1 0x55
        v0 = n_valid_cyc;
        expect_char(8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        chk("t1_valid_cycles", n_valid_cyc - v0, 1);

        // 2: false start, 3 low ticks then high
        v0 = n_valid_cyc;
        rx_serial_sync = 1'b0;
        repeat (3) tick();
        chk("t2_active_start", {31'd0, rx_active}, 1);
        rx_serial_sync = 1'b1;
        repeat (7) tick();
        chk("t2_active_cnt8", {31'd0, rx_active}, 1);
        tick();
        chk("t2_active_cnt9", {31'd0, rx_active}, 0);
        send_bit(1'b1);
        chk("t2_no_valid", n_valid_cyc - v0, 0);

        // 3: 7E1 0x41 with wrong then right parity, then 7O1
        cfg_data_bits = 2'b10; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
        expect_char(8'h41, 1'b1, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        send_bit(1'b1);
        expect_char(8'h41, 1'b0, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1);
        cfg_parity_odd = 1'b1;
        expect_char(8'h41, 1'b0, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        send_bit(1'b1);

        // 5N1: upper bits of the pattern are not on the line
        cfg_data_bits = 2'b00; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
        expect_char(8'h15, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF5, 5, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);

        // 4: framing error, then a held break
        cfg_data_bits = 2'b11;
        expect_char(8'hA3, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1);
        chk("t4_idle_after_fe", {31'd0, rx_active}, 0);
        v0 = n_valid_cyc;
        expect_char(8'h00, 1'b0, 1'b1, 1'b1);
        repeat (20) send_bit(1'b0);
        chk("t4_brk_wait", {31'd0, rx_active}, 1);
        send_bit(1'b1);
        chk("t4_idle_after_brk", {31'd0, rx_active}, 0);
        chk("t4_one_valid", n_valid_cyc - v0, 1);

        // 5: overrun with rx_ready low
        rx_ready = 1'b0;
        o0 = n_ovr;
        expect_char(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        chk("t5_held_data", {24'd0, rx_data}, 32'h11);
        chk("t5_held_valid", {31'd0, rx_valid}, 1);
        chk("t5_overrun_pulses", n_ovr - o0, 1);
        rx_ready = 1'b1;
        repeat (3) @(posedge uart_clk);
        #2;
        chk("t5_valid_cleared", {31'd0, rx_valid}, 0);

        // 6: reset mid-DATA of 0x7E, then 0x3C
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        uart_rst_n = 1'b0;
        repeat (3) @(posedge uart_clk);
        #2;
        chk("t6_reset_outputs",
            {18'd0, rx_data, rx_valid, parity_error, frame_error, break_detect, overrun, rx_active},
            32'd0);
        uart_rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        expect_char(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
